// File: rtl/ps2_kbd_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : ps2_kbd_rx_if
// Brief    : Bus-side keyboard window signals between ps2_kbd_rx and the MMIO bus.
// Revision : 1.0 - initial release
// ============================================================================
interface ps2_kbd_rx_if;
    logic       ps2kb_rd;
    logic [9:0] ps2kb_key;
    logic       ps2_ready;
    logic       ps2_overflow;
    logic       frame_err;

    modport master (
        output ps2kb_rd,
        input  ps2kb_key,
        input  ps2_ready,
        input  ps2_overflow,
        input  frame_err
    );

    modport slave (
        input  ps2kb_rd,
        output ps2kb_key,
        output ps2_ready,
        output ps2_overflow,
        output frame_err
    );
endinterface
`default_nettype wire

// File: rtl/ps2_kbd_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_kbd_rx
// Brief    : PS/2 keyboard receiver: pin conditioning, frame deframing,
//            E0/F0 prefix folding and a key-code FIFO popped by the bus.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_kbd_rx #(
    parameter int FIFO_AW    = 3,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ps2_clk,
    input  logic         ps2_data,
    ps2_kbd_rx_if.slave  bus
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int FW    = $clog2(FILTER_LEN + 1);
    localparam int WW    = $clog2(TIMEOUT + 1);
    localparam logic [FW-1:0] c_FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [WW-1:0] c_WD_LAST   = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    logic [1:0]    r_clk_sync;
    logic [1:0]    r_data_sync;
    logic          r_clk_filt;
    logic [FW-1:0] r_filt_cnt;
    logic          r_fall;
    logic          w_data;

    assign w_data = r_data_sync[1];

    // The filtered clock only moves once FILTER_LEN consecutive samples disagree with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_clk_filt  <= 1'b1;
            r_filt_cnt  <= '0;
            r_fall      <= 1'b0;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], ps2_clk};
            r_data_sync <= {r_data_sync[0], ps2_data};
            r_fall      <= 1'b0;
            if (r_clk_sync[1] == r_clk_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == c_FILT_LAST) begin
                r_clk_filt <= r_clk_sync[1];
                r_filt_cnt <= '0;
                r_fall     <= r_clk_filt;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    state_t        r_state;
    state_t        w_state_nxt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_parity;
    logic [WW-1:0] r_wd;
    logic          r_ext;
    logic          r_brk;
    logic          r_frame_err;
    logic          w_timeout;
    logic          w_valid;
    logic          w_push;
    logic          w_err;
    logic          w_set_ext;
    logic          w_set_brk;
    logic          w_clr_flags;

    assign w_timeout = (r_state != S_IDLE) && !r_fall && (r_wd == c_WD_LAST);
    assign w_valid   = w_data & (^{r_shift, r_parity});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_err       = 1'b0;
        w_set_ext   = 1'b0;
        w_set_brk   = 1'b0;
        w_clr_flags = 1'b0;
        case (r_state)
            S_IDLE:   if (r_fall && !w_data) w_state_nxt = S_DATA;
            S_DATA:   if (r_fall && r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
            S_PARITY: if (r_fall) w_state_nxt = S_STOP;
            S_STOP: begin
                if (r_fall) begin
                    w_state_nxt = S_IDLE;
                    if (!w_valid) begin
                        w_err       = 1'b1;
                        w_clr_flags = 1'b1;
                    end else if (r_shift == 8'hE0) begin
                        w_set_ext   = 1'b1;
                    end else if (r_shift == 8'hF0) begin
                        w_set_brk   = 1'b1;
                    end else begin
                        w_push      = 1'b1;
                        w_clr_flags = 1'b1;
                    end
                end
            end
            default:  w_state_nxt = S_IDLE;
        endcase
        // A stalled frame is abandoned silently; prefix flags survive it.
        if (w_timeout) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_parity    <= 1'b0;
            r_wd        <= '0;
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_err;
            if (r_state == S_IDLE || r_fall) r_wd <= '0;
            else                             r_wd <= r_wd + 1'b1;
            if (r_fall) begin
                case (r_state)
                    S_IDLE:   r_bit_cnt <= '0;
                    S_DATA: begin
                        r_shift   <= {w_data, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                    S_PARITY: r_parity <= w_data;
                    default:  ;
                endcase
            end
            if (w_clr_flags) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end
            if (w_set_ext) r_ext <= 1'b1;
            if (w_set_brk) r_brk <= 1'b1;
        end
    end

    logic [9:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               r_rd_prev;
    logic               r_overflow;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push_ok;

    assign w_empty   = (r_count == '0);
    assign w_full    = r_count[FIFO_AW];
    // Pop on the falling edge of the read strobe so the head holds for the whole access.
    assign w_pop     = r_rd_prev & ~bus.ps2kb_rd & ~w_empty;
    assign w_push_ok = w_push & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= {r_brk, r_ext, r_shift};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_prev  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_rd_prev <= bus.ps2kb_rd;
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
            if (w_push && !w_push_ok) r_overflow <= 1'b1;
            else if (w_pop)           r_overflow <= 1'b0;
        end
    end

    assign bus.ps2kb_key    = w_empty ? 10'h000 : r_mem[r_rd_ptr];
    assign bus.ps2_ready    = ~w_empty;
    assign bus.ps2_overflow = r_overflow;
    assign bus.frame_err    = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_kbd_rx
// Brief    : Self-checking bench for ps2_kbd_rx against a queue-based key model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_kbd_rx;

    localparam int TB_TIMEOUT = 1000;
    localparam int HALF       = 20;

    logic clk = 1'b0;
    logic rst;
    logic ps2_clk;
    logic ps2_data;
    ps2_kbd_rx_if bus();

    ps2_kbd_rx #(
        .FIFO_AW    (3),
        .FILTER_LEN (8),
        .TIMEOUT    (TB_TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int err_seen = 0;

    // Reference model: key queue, prefix flags, sticky overflow, error count.
    logic [9:0] mq[$];
    bit m_ext = 0;
    bit m_brk = 0;
    bit m_ov  = 0;
    int m_errs = 0;

    always @(negedge clk) if (bus.frame_err === 1'b1) err_seen++;

    function automatic void cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void model_frame(input logic [7:0] d, input bit par, input bit stp);
        if (!(stp && ((^d ^ par) == 1'b1))) begin
            m_ext = 0; m_brk = 0; m_errs++;
        end else if (d == 8'hE0) begin
            m_ext = 1;
        end else if (d == 8'hF0) begin
            m_brk = 1;
        end else begin
            if (mq.size() < 8) mq.push_back({m_brk, m_ext, d});
            else m_ov = 1;
            m_ext = 0; m_brk = 0;
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input bit b);
        ps2_data = b;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_raw(input logic [7:0] d, input bit par, input bit stp, input int nbits);
        logic [10:0] f;
        f = {stp, par, d, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
        ps2_data = 1'b1;
        tick(2 * HALF);
        if (nbits == 11) model_frame(d, par, stp);
    endtask

    task automatic send_key(input logic [7:0] d);
        send_raw(d, ~^d, 1'b1, 11);
    endtask

    task automatic check_all(input string nm);
        @(negedge clk);
        cmp({nm, "_ready"}, bus.ps2_ready, (mq.size() != 0));
        cmp({nm, "_key"}, bus.ps2kb_key, (mq.size() != 0) ? mq[0] : 10'h000);
        cmp({nm, "_ovf"}, bus.ps2_overflow, m_ov);
        cmp({nm, "_errs"}, err_seen, m_errs);
    endtask

    task automatic do_pop(input int hold);
        logic [9:0] head;
        head = (mq.size() != 0) ? mq[0] : 10'h000;
        bus.ps2kb_rd = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            cmp("pop_hold_key", bus.ps2kb_key, head);
        end
        @(posedge clk);
        #1 bus.ps2kb_rd = 1'b0;
        if (mq.size() != 0) begin
            void'(mq.pop_front());
            m_ov = 0;
        end
        tick(2);
        check_all("pop");
    endtask

    typedef struct {
        logic [7:0] d;
        bit         par_bad;
        bit         stp;
        logic [9:0] key;
        bit         rdy;
        int         err;
    } vec_t;

    vec_t vecs[14];

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [10:0] f;
        bit found;
        int eb;
        logic [7:0] rb;
        bit pb, sb;

        vecs[0]  = '{8'h1C, 1'b0, 1'b1, 10'h01C, 1'b1, 0};
        vecs[1]  = '{8'h1C, 1'b1, 1'b1, 10'h000, 1'b0, 1};
        vecs[2]  = '{8'h5A, 1'b0, 1'b0, 10'h000, 1'b0, 1};
        vecs[3]  = '{8'hE0, 1'b0, 1'b1, 10'h000, 1'b0, 0};
        vecs[4]  = '{8'h75, 1'b0, 1'b1, 10'h175, 1'b1, 0};
        vecs[5]  = '{8'hF0, 1'b0, 1'b1, 10'h000, 1'b0, 0};
        vecs[6]  = '{8'hE0, 1'b0, 1'b1, 10'h000, 1'b0, 0};
        vecs[7]  = '{8'h6B, 1'b0, 1'b1, 10'h36B, 1'b1, 0};
        vecs[8]  = '{8'hF0, 1'b0, 1'b1, 10'h000, 1'b0, 0};
        vecs[9]  = '{8'h2A, 1'b1, 1'b1, 10'h000, 1'b0, 1};
        vecs[10] = '{8'h2A, 1'b0, 1'b1, 10'h02A, 1'b1, 0};
        vecs[11] = '{8'h00, 1'b0, 1'b1, 10'h000, 1'b1, 0};
        vecs[12] = '{8'hFF, 1'b0, 1'b1, 10'h0FF, 1'b1, 0};
        vecs[13] = '{8'hE1, 1'b0, 1'b1, 10'h0E1, 1'b1, 0};

        rst = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; bus.ps2kb_rd = 1'b0;
        tick(4);
        check_all("reset");
        cmp("reset_frame_err", bus.frame_err, 1'b0);
        rst = 1'b1;
        tick(4);

        // Latency of the first key relative to the final ps2_clk fall.
        f = {1'b1, ~^8'h1C, 8'h1C, 1'b0};
        for (int i = 0; i < 10; i++) ps2_bit(f[i]);
        ps2_data = 1'b1;
        tick(HALF);
        @(negedge clk);
        cmp("lat_not_early", bus.ps2_ready, 1'b0);
        @(posedge clk); #1 ps2_clk = 1'b0;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.ps2_ready === 1'b1) begin found = 1; break; end
        end
        cmp("lat_ready_seen", found, 1'b1);
        cmp("lat_key", bus.ps2kb_key, 10'h01C);
        tick(HALF);
        ps2_clk = 1'b1;
        tick(2 * HALF);
        model_frame(8'h1C, ~^8'h1C, 1'b1);
        check_all("first_key");
        do_pop(3);
        cmp("pop_empty_key", bus.ps2kb_key, 10'h000);

        // Prefix folding.
        send_key(8'hE0); send_key(8'hF0); send_key(8'h75);
        check_all("e0f0_75");
        cmp("e0f0_75_const", bus.ps2kb_key, 10'h375);
        send_key(8'h75);
        do_pop(1);
        cmp("plain_75_const", bus.ps2kb_key, 10'h075);
        do_pop(1);

        // Errors clear prefixes and raise a single pulse.
        send_raw(8'h1C, ~(~^8'h1C), 1'b1, 11);
        check_all("bad_par");
        send_key(8'hF0);
        send_raw(8'h33, ~^8'h33, 1'b0, 11);
        send_key(8'h1C);
        check_all("brk_cleared");
        cmp("brk_cleared_const", bus.ps2kb_key, 10'h01C);
        do_pop(2);

        for (int v = 0; v < 14; v++) begin
            eb = err_seen;
            send_raw(vecs[v].d, (~^vecs[v].d) ^ vecs[v].par_bad, vecs[v].stp, 11);
            @(negedge clk);
            cmp("vec_ready", bus.ps2_ready, vecs[v].rdy);
            cmp("vec_key", bus.ps2kb_key, vecs[v].key);
            cmp("vec_err", err_seen - eb, vecs[v].err);
            if (vecs[v].rdy) do_pop(1);
        end

        // Overflow: ninth key dropped, order preserved.
        for (int k = 0; k < 9; k++) send_key(8'h10 + 8'(k));
        check_all("full");
        cmp("ovf_set", bus.ps2_overflow, 1'b1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            cmp("ovf_order", bus.ps2kb_key, 10'h010 + 10'(k));
            do_pop(1);
            if (k == 0) cmp("ovf_clear", bus.ps2_overflow, 1'b0);
        end
        cmp("ovf_drained", bus.ps2_ready, 1'b0);

        // Partial frame abandoned by the watchdog.
        eb = err_seen;
        send_raw(8'h55, 1'b0, 1'b1, 4);
        tick(TB_TIMEOUT + 10);
        send_key(8'h2A);
        check_all("timeout");
        cmp("timeout_key", bus.ps2kb_key, 10'h02A);
        cmp("timeout_no_err", err_seen - eb, 0);
        do_pop(1);

        // Asynchronous reset mid-frame with entries queued.
        send_key(8'h21); send_key(8'h22);
        send_raw(8'h44, 1'b0, 1'b1, 5);
        tick(1);
        #2 rst = 1'b0;
        #1;
        cmp("arst_ready", bus.ps2_ready, 1'b0);
        cmp("arst_key", bus.ps2kb_key, 10'h000);
        cmp("arst_ovf", bus.ps2_overflow, 1'b0);
        cmp("arst_err", bus.frame_err, 1'b0);
        mq.delete(); m_ext = 0; m_brk = 0; m_ov = 0;
        tick(3);
        rst = 1'b1;
        tick(3);
        send_key(8'h1C);
        check_all("post_reset");
        cmp("post_reset_key", bus.ps2kb_key, 10'h01C);
        do_pop(1);

        // Randomized traffic against the model.
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 9))
                0:       rb = 8'hE0;
                1:       rb = 8'hF0;
                default: rb = 8'($urandom_range(0, 255));
            endcase
            pb = ($urandom_range(0, 7) == 0);
            sb = ($urandom_range(0, 15) != 0);
            send_raw(rb, (~^rb) ^ pb, sb, 11);
            check_all("rand");
            if ($urandom_range(0, 2) == 0) do_pop($urandom_range(1, 3));
        end
        for (int k = 0; k < 10 && mq.size() != 0; k++) do_pop(1);
        check_all("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
